// File: rtl/display_pkg.sv
// Shared types and segment constants for the 7-segment scan controller.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package display_pkg;

  typedef enum logic {
    SHOW,
    BLANK
  } state_t;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

endpackage

// File: rtl/display_scan_ctrl_seg7.sv
// Nibble to active-low 7-segment glyph; non-decimal nibbles show a dash.
// A high blank input turns every segment off.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      unique case (nib)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed display scanner with per-slot blanking gap and
// a shadow register that commits new values only at frame boundaries.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int TICK_DIV  = 25000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  dp_in,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic [3:0]  digit_sel,
  output logic        DP,
  output logic        frame_done
);

  localparam int MX = (TICK_DIV > BLANK_CYC) ? TICK_DIV : BLANK_CYC;
  localparam int CW = $clog2(MX + 1);
  localparam int BL = (BLANK_CYC > 0) ? BLANK_CYC - 1 : 0;

  localparam logic [CW-1:0] T_LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] B_LAST = CW'(BL);

  state_t        st, st_n;
  logic [1:0]    k, k_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          run;

  logic [15:0] bcd_act, bcd_sh, bcd_n;
  logic [3:0]  dp_act, dp_sh, dp_n;
  logic        pending, commit, bnd_n;

  logic [3:0] hz;
  logic       lz_blk;
  logic [6:0] seg_d;

  assign load_ready = !pending;
  assign commit     = frame_done && pending;

  // Outputs for the next slot must already see a value committed this edge
  assign bcd_n = commit ? bcd_sh : bcd_act;
  assign dp_n  = commit ? dp_sh  : dp_act;

  always_comb begin
    st_n  = st;
    k_n   = k;
    cnt_n = cnt;
    if (run) begin
      if (st == SHOW) begin
        if (cnt == T_LAST) begin
          cnt_n = '0;
          if (BLANK_CYC > 0) st_n = BLANK;
          else               k_n  = k + 2'd1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end else begin
        if (cnt == B_LAST) begin
          cnt_n = '0;
          st_n  = SHOW;
          k_n   = k + 2'd1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
    end
  end

  always_comb begin
    if (BLANK_CYC > 0)
      bnd_n = (st_n == BLANK) && (k_n == 2'd3) && (cnt_n == B_LAST);
    else
      bnd_n = (st_n == SHOW) && (k_n == 2'd3) && (cnt_n == T_LAST);
  end

  // hz[i]: nibble i and every nibble above it are zero
  assign hz[3] = (bcd_n[15:12] == 4'd0);
  assign hz[2] = hz[3] && (bcd_n[11:8] == 4'd0);
  assign hz[1] = hz[2] && (bcd_n[7:4] == 4'd0);
  assign hz[0] = 1'b0;

  assign lz_blk = blank_lz && hz[k_n];

  seg7_decode u_dec (
    .nib   (bcd_n[{k_n, 2'b00} +: 4]),
    .blank ((st_n != SHOW) || lz_blk),
    .seg   (seg_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st  <= SHOW;
      k   <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else begin
      st  <= st_n;
      k   <= k_n;
      cnt <= cnt_n;
      run <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_act <= '0;
      dp_act  <= '0;
      bcd_sh  <= '0;
      dp_sh   <= '0;
      pending <= 1'b0;
    end else begin
      if (commit) begin
        bcd_act <= bcd_sh;
        dp_act  <= dp_sh;
        pending <= 1'b0;
      end else if (load_valid && load_ready) begin
        bcd_sh  <= bcd_in;
        dp_sh   <= dp_in;
        pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= SEG_BLANK;
      digit_sel  <= 4'hF;
      DP         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_d;
      digit_sel  <= (st_n == SHOW) ? ~(4'b0001 << k_n) : 4'hF;
      DP         <= (st_n == SHOW) ? ~dp_n[k_n] : 1'b1;
      frame_done <= bnd_n;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench: accepted loads queue up, the monitor commits them at
// modelled frame boundaries and checks every output cycle against a model.
module tb_display_scan_ctrl;

  localparam int TD = 4;
  localparam int BC = 2;
  localparam int FR = 4 * (TD + BC);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] bcd_in = '0;
  logic [3:0]  dp_in = '0;
  logic        load_valid = 1'b0;
  logic        blank_lz = 1'b0;
  logic        load_ready;
  logic [6:0]  seg;
  logic [3:0]  digit_sel;
  logic        DP;
  logic        frame_done;

  logic        rdy0;
  logic [6:0]  seg0;
  logic [3:0]  sel0;
  logic        dp0;
  logic        fd0;

  display_scan_ctrl #(.TICK_DIV(TD), .BLANK_CYC(BC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bcd_in     (bcd_in),
    .dp_in      (dp_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .digit_sel  (digit_sel),
    .DP         (DP),
    .frame_done (frame_done)
  );

  display_scan_ctrl #(.TICK_DIV(TD), .BLANK_CYC(0)) dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .bcd_in     (16'h0000),
    .dp_in      (4'h0),
    .load_valid (1'b0),
    .load_ready (rdy0),
    .blank_lz   (1'b0),
    .seg        (seg0),
    .digit_sel  (sel0),
    .DP         (dp0),
    .frame_done (fd0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  dp;
  } ld_t;

  ld_t         q[$];
  int          checks = 0;
  int          failures = 0;
  int          t = 0;
  int          t0 = 0;
  bit          run_seen = 1'b0;
  logic        blz_s = 1'b0;
  logic [15:0] cur = '0;
  logic [3:0]  curdp = '0;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  // {digit_sel, seg, DP, frame_done} for cycle s of a scan
  function automatic logic [12:0] expect_out(
    input int s, input int tick, input int blk,
    input logic [15:0] v, input logic [3:0] dpv, input logic blz);
    int          slot;
    int          ph;
    int          d;
    bit          show;
    bit          lz;
    logic [15:0] hi;
    logic [3:0]  sel;
    logic [6:0]  sg;
    logic        dpo;
    logic        fd;
    slot = tick + blk;
    ph   = s % (4 * slot);
    d    = ph / slot;
    show = (ph % slot) < tick;
    hi   = v >> (4 * d);
    lz   = blz && (d > 0) && (hi == 16'h0);
    sel  = show ? ~(4'b0001 << d) : 4'hF;
    sg   = (!show || lz) ? 7'h7F : glyph(hi[3:0]);
    dpo  = show ? ~dpv[d] : 1'b1;
    fd   = (ph == 4 * slot - 1);
    return {sel, sg, dpo, fd};
  endfunction

  task automatic check(input string nm, input logic [13:0] act,
                       input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%h want=%h (sel,seg,dp,fd,rdy)",
               nm, t, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_seen <= 1'b0;
      q.delete();
    end else begin
      if (load_valid && load_ready)
        q.push_back('{bcd: bcd_in, dp: dp_in});
      blz_s    <= blank_lz;
      run_seen <= 1'b1;
    end
  end

  always @(negedge clk) begin
    logic [12:0] e;
    logic [12:0] e0;
    ld_t         it;
    if (!rst_n) begin
      t     = 0;
      t0    = 0;
      cur   = '0;
      curdp = '0;
    end else if (run_seen) begin
      e  = expect_out(t, TD, BC, cur, curdp, blz_s);
      check("scan", {digit_sel, seg, DP, frame_done, load_ready},
            {e, (q.size() == 0)});
      e0 = expect_out(t0, TD, 0, 16'h0, 4'h0, 1'b0);
      check("scan_noblank", {sel0, seg0, dp0, fd0, rdy0}, {e0, 1'b1});
      if ((t % FR) == FR - 1 && q.size() > 0) begin
        it    = q.pop_front();
        cur   = it.bcd;
        curdp = it.dp;
      end
      t++;
      t0++;
    end
  end

  task automatic load(input logic [15:0] v, input logic [3:0] d);
    int n;
    bit acc;
    n   = 0;
    acc = 1'b0;
    bcd_in     = v;
    dp_in      = d;
    load_valid = 1'b1;
    while (!acc && n < 200) begin
      acc = load_ready;
      @(negedge clk);
      n++;
    end
    load_valid = 1'b0;
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL load_timeout got=0 want=1 value=%h", v);
    end
  endtask

  task automatic check_reset(input string nm);
    check(nm, {digit_sel, seg, DP, frame_done, load_ready},
          {4'hF, 7'h7F, 1'b1, 1'b0, 1'b1});
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset_state");
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2 * FR) @(negedge clk);

    load(16'h1234, 4'b0100);
    repeat (2 * FR) @(negedge clk);

    load(16'h1111, 4'h0);
    load(16'h2222, 4'h0);
    repeat (3 * FR) @(negedge clk);

    blank_lz = 1'b1;
    load(16'h0005, 4'h0);
    repeat (2 * FR) @(negedge clk);
    load(16'h0000, 4'h0);
    repeat (2 * FR) @(negedge clk);
    blank_lz = 1'b0;

    load(16'hA0FA, 4'b1001);
    repeat (2 * FR) @(negedge clk);

    repeat (30) begin
      if ($urandom_range(0, 3) == 0) blank_lz = 1'($urandom);
      load(16'($urandom), 4'($urandom));
      repeat ($urandom_range(0, FR)) @(negedge clk);
    end
    blank_lz = 1'b0;
    repeat (2 * FR) @(negedge clk);

    n = 0;
    while (!frame_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!frame_done) begin
      failures++;
      $display("FAIL frame_wait got=0 want=1");
    end
    load(16'h9876, 4'hF);
    repeat (13) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset("async_reset");
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2 * FR) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexing scan controller for the board's 4-digit common-anode 7-segment display. It takes a 16-bit packed BCD value plus per-digit decimal points through a valid/ready load port and drives one digit at a time. Each digit slot ends with a blanking gap to suppress ghosting. New values are committed only at frame boundaries, so the display never tears. It sits between the BCD-producing datapath (e.g. the ones-count → bin-to-BCD chain) and the seg/digit_sel/DP board pins.

## Interface
Parameters:
- TICK_DIV, 25000, clk cycles each digit is driven (SHOW phase); ≥2
- BLANK_CYC, 16, clk cycles all anodes off after each digit (BLANK phase); 0 = no blanking

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  reset, asynchronous and active-low
- bcd_in  in  16  packed BCD, [3:0] = digit 0 (rightmost) … [15:12] = digit 3
- dp_in  in  4  decimal point request per digit, 1 = lit
- load_valid  in  1  bcd_in/dp_in valid
- load_ready  out  1  high when the shadow register is empty
- blank_lz  in  1  1 = leading-zero blanking enabled (sampled live)
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- digit_sel  out  4  anodes, active-low, bit k = digit k
- DP  out  1  decimal point, active-low
- frame_done  out  1  one-cycle pulse at each frame boundary

## Operation
- Reset state:
  - FSM in SHOW, digit index 0, counters 0.
  - Active value 0, dp 0, shadow empty.
  - Outputs: digit_sel=4'b1111, seg=7'h7F, DP=1, frame_done=0.
  - load_ready=1 (combinational !pending).
- FSM states:
  - SHOW(k): drive digit k for TICK_DIV cycles.
    - If BLANK_CYC>0, go to BLANK(k).
    - Otherwise go directly to SHOW((k+1) mod 4).
  - BLANK(k): digit_sel=4'b1111, seg=7'h7F, DP=1 for BLANK_CYC cycles, then SHOW((k+1) mod 4).
- Frame boundary: the cycle in which digit 3's slot ends (last BLANK(3) cycle, or last SHOW(3) cycle when BLANK_CYC=0).
  - frame_done=1 for that cycle.
  - If pending, shadow is copied to the active registers and pending is cleared.
- Load handshake:
  - Transfer when load_valid && load_ready. bcd_in/dp_in are captured into the shadow and pending is set.
  - load_valid while not ready: no effect; the producer must hold its data.
  - Accept and boundary in the same cycle: impossible, since a boundary copy only happens when pending=1, which forces ready=0. Ready rises the cycle after the copy.
- Digit decode (seg7_decode):
  - Nibble 0–9 gives the standard glyph.
  - Nibble 10–15 gives "-" (seg=7'b0111111).
- Leading-zero blanking (blank_lz=1): digit k∈{3,2,1} is blanked (seg=7'h7F, DP still from dp) when its nibble and all higher nibbles are 0. Digit 0 is never blanked.
- DP: DP = ~dp_active[k] during SHOW(k).
- Reset mid-operation: all state returns to reset values immediately (async) and any pending shadow is discarded.

## Timing
- Outputs (seg, digit_sel, DP, frame_done) are registered and change on the edge at which the FSM enters the corresponding state. Each SHOW is exactly TICK_DIV cycles, each BLANK exactly BLANK_CYC cycles.
- Frame period = 4·(TICK_DIV+BLANK_CYC) cycles.
- Load-to-display latency: the commit occurs at the next frame boundary. The new digit 0 appears on the following cycle, worst case one full frame + 1 cycle after acceptance.
- The first SHOW(0) after reset release begins on the first rising edge with rst_n=1. Outputs are valid from that edge.
- Counter width: $clog2(max(TICK_DIV,BLANK_CYC)+1). No wrap beyond the terminal count.

## Structure
- Package display_pkg:
  - state enum {SHOW, BLANK}
  - NUM_DIGITS=4
  - SEG_BLANK=7'h7F, SEG_DASH=7'b0111111
  - glyph constants for 0–9
- Sub-module seg7_decode: combinational 4-bit nibble → 7-bit active-low segments, with a blank input.
- The top FSM, counters, shadow/active registers and leading-zero logic live in display_scan_ctrl.

## Test plan
All scenarios use TICK_DIV=4, BLANK_CYC=2 (frame = 24 cycles).
- Reset scan, no load, blank_lz=0:
  - digit_sel sequence 1110×4, 1111×2, 1101×4, 1111×2, …
  - seg=7'h40 ("0") during every SHOW.
  - frame_done pulses every 24 cycles.
- Load 16'h1234, dp_in=4'b0100:
  - load_ready drops the next cycle.
  - After the next frame_done: digit 3 shows "1" (7'h79), digit 0 shows "4" (7'h19), DP=0 only during SHOW(2).
  - load_ready returns to 1 the cycle after frame_done.
- Back-pressure: load 16'h1111, then hold load_valid with 16'h2222 while ready=0.
  - 16'h2222 is accepted the cycle after the first commit.
  - 16'h2222 is displayed one frame later; no value is lost.
- blank_lz=1 with value 16'h0005: digits 3–1 show seg=7'h7F, digit 0 shows "5". With 16'h0000, digit 0 shows "0".
- Nibble 4'hA: that digit shows seg=7'b0111111.
- BLANK_CYC=0: no all-off cycles, frame = 16 cycles.
- rst_n pulsed low mid-SHOW(2) with pending=1: outputs go to reset values asynchronously, pending is cleared, and scanning restarts at digit 0 displaying "0000".
